// File: rtl/color_pkg.sv
// Shared encodings for the colour vote classifier: frame classes, RESULT bit
// positions, screen geometry and the background colour.
package color_pkg;

  typedef enum logic [1:0] {
    CLS_NULL = 2'd0,
    CLS_RED  = 2'd1,
    CLS_BLUE = 2'd2
  } frame_cls_e;

  localparam int RES_RED  = 3;
  localparam int RES_BLUE = 4;
  localparam int RES_NULL = 5;

  localparam int SCREEN_WIDTH  = 176;
  localparam int SCREEN_HEIGHT = 144;

  localparam logic [7:0] WHITE = 8'hFF;

  // Map a class onto the Arduino-facing RESULT layout; bits [2:0] stay zero.
  function automatic logic [5:0] class_onehot(input frame_cls_e cls);
    logic [5:0] res;
    res = '0;
    case (cls)
      CLS_RED:  res[RES_RED]  = 1'b1;
      CLS_BLUE: res[RES_BLUE] = 1'b1;
      default:  res[RES_NULL] = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pixel_color_classify.sv
// Combinational RGB332 pixel classifier: white is background, red wins over blue.
module pixel_color_classify
  import color_pkg::*;
#(
  parameter logic [2:0] R_MIN = 3'd1,
  parameter logic [1:0] B_MIN = 2'd1
) (
  input  logic [7:0] pixel,
  output logic       is_red,
  output logic       is_blue
);

  logic not_white;

  assign not_white = (pixel != WHITE);
  assign is_red    = not_white && (pixel[7:5] >= R_MIN);
  assign is_blue   = not_white && !is_red && (pixel[1:0] >= B_MIN);

endmodule

// File: rtl/color_vote_classifier.sv
// Per-frame red/blue pixel counting inside an ROI, frame decision on the vsync
// falling edge, and a majority vote over VOTE_FRAMES frames driving RESULT.
module color_vote_classifier
  import color_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int R_MIN       = 1,
  parameter int B_MIN       = 1,
  parameter int CNT_MIN     = 5000,
  parameter int VOTE_FRAMES = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_WIDTH - 1,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = SCREEN_HEIGHT - 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PIXEL_IN,
  input  logic       PIXEL_VALID,
  input  logic [9:0] VGA_PIXEL_X,
  input  logic [9:0] VGA_PIXEL_Y,
  input  logic       VGA_VSYNC_NEG,
  output logic [5:0] RESULT,
  output logic       RESULT_VALID,
  output logic [1:0] FRAME_CLASS
);

  if (VOTE_FRAMES < 1 || VOTE_FRAMES > 255) begin : g_bad_vote_frames
    $error("VOTE_FRAMES must be in 1..255");
  end
  if (X_MIN > X_MAX || Y_MIN > Y_MAX) begin : g_bad_roi
    $error("ROI minimum exceeds maximum");
  end
  if (64'(CNT_MIN) >= (64'd1 << CNT_W)) begin : g_bad_cnt_min
    $error("CNT_MIN does not fit in CNT_W bits");
  end

  localparam int VW = $clog2(VOTE_FRAMES + 1);

  // state            | meaning
  // IDLE_AFTER_RESET | first cycle out of reset, nothing voted yet
  // COUNTING         | accumulating pixels and frame votes
  // VOTE_CLOSE       | window just closed, RESULT_VALID high for this cycle
  localparam logic [1:0] IDLE_AFTER_RESET = 2'd0;
  localparam logic [1:0] COUNTING         = 2'd1;
  localparam logic [1:0] VOTE_CLOSE       = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MIN_L = CNT_W'(CNT_MIN);
  localparam logic [VW-1:0]    VF_L      = VW'(VOTE_FRAMES);
  localparam logic [9:0]       X_MIN_L   = 10'(X_MIN);
  localparam logic [9:0]       Y_MIN_L   = 10'(Y_MIN);
  localparam logic [9:0]       X_SPAN    = 10'(X_MAX - X_MIN);
  localparam logic [9:0]       Y_SPAN    = 10'(Y_MAX - Y_MIN);

  logic is_red, is_blue;

  pixel_color_classify #(
    .R_MIN(3'(R_MIN)),
    .B_MIN(2'(B_MIN))
  ) u_classify (
    .pixel  (PIXEL_IN),
    .is_red (is_red),
    .is_blue(is_blue)
  );

  // Offset-and-compare gives an inclusive range check in one unsigned compare.
  logic [9:0] dx, dy;
  logic       in_roi, qual_red, qual_blue;

  assign dx        = VGA_PIXEL_X - X_MIN_L;
  assign dy        = VGA_PIXEL_Y - Y_MIN_L;
  assign in_roi    = (dx <= X_SPAN) && (dy <= Y_SPAN);
  assign qual_red  = PIXEL_VALID && in_roi && is_red;
  assign qual_blue = PIXEL_VALID && in_roi && is_blue;

  logic vsync_q, boundary;
  assign boundary = vsync_q && !VGA_VSYNC_NEG;

  logic [CNT_W-1:0] cnt_red, cnt_blue;
  frame_cls_e       frame_cls_d, frame_class_q;

  always_comb begin
    frame_cls_d = CLS_NULL;
    if (cnt_red > cnt_blue && cnt_red >= CNT_MIN_L) begin
      frame_cls_d = CLS_RED;
    end else if (cnt_blue > cnt_red && cnt_blue >= CNT_MIN_L) begin
      frame_cls_d = CLS_BLUE;
    end
  end

  logic [VW-1:0] vote_red, vote_blue, vote_null, frame_idx;
  logic [VW-1:0] vr_n, vb_n, vn_n, frame_idx_n;
  logic          window_close;
  frame_cls_e    vote_cls_d;

  assign vr_n         = vote_red  + VW'(frame_cls_d == CLS_RED);
  assign vb_n         = vote_blue + VW'(frame_cls_d == CLS_BLUE);
  assign vn_n         = vote_null + VW'(frame_cls_d == CLS_NULL);
  assign frame_idx_n  = frame_idx + VW'(1);
  assign window_close = boundary && (frame_idx_n == VF_L);

  always_comb begin
    vote_cls_d = CLS_NULL;
    if (vr_n > vb_n && vr_n >= vn_n) begin
      vote_cls_d = CLS_RED;
    end else if (vb_n > vr_n && vb_n > vn_n) begin
      vote_cls_d = CLS_BLUE;
    end
  end

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = COUNTING;
    case (state_q)
      IDLE_AFTER_RESET,
      COUNTING,
      VOTE_CLOSE: state_d = window_close ? VOTE_CLOSE : COUNTING;
      default:    state_d = COUNTING;
    endcase
  end

  logic [5:0] result_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vsync_q       <= 1'b1;
      cnt_red       <= '0;
      cnt_blue      <= '0;
      frame_class_q <= CLS_NULL;
      vote_red      <= '0;
      vote_blue     <= '0;
      vote_null     <= '0;
      frame_idx     <= '0;
      result_q      <= class_onehot(CLS_NULL);
      state_q       <= IDLE_AFTER_RESET;
    end else begin
      vsync_q <= VGA_VSYNC_NEG;
      state_q <= state_d;
      if (boundary) begin
        // The pixel arriving on the boundary cycle belongs to the new frame.
        cnt_red       <= CNT_W'(qual_red);
        cnt_blue      <= CNT_W'(qual_blue);
        frame_class_q <= frame_cls_d;
        if (window_close) begin
          vote_red  <= '0;
          vote_blue <= '0;
          vote_null <= '0;
          frame_idx <= '0;
          result_q  <= class_onehot(vote_cls_d);
        end else begin
          vote_red  <= vr_n;
          vote_blue <= vb_n;
          vote_null <= vn_n;
          frame_idx <= frame_idx_n;
        end
      end else begin
        if (qual_red && cnt_red != CNT_MAX) begin
          cnt_red <= cnt_red + CNT_W'(1);
        end
        if (qual_blue && cnt_blue != CNT_MAX) begin
          cnt_blue <= cnt_blue + CNT_W'(1);
        end
      end
    end
  end

  assign RESULT       = result_q;
  assign RESULT_VALID = (state_q == VOTE_CLOSE);
  assign FRAME_CLASS  = frame_class_q;

endmodule

// File: doc/color_vote_classifier.md
Name: color_vote_classifier

Overview:
- Parametrised successor to the camera colour detector. Classifies each RGB332 pixel as red, blue or background and counts classes per frame inside a programmable region of interest (ROI).
- Decides each frame's colour, then majority-votes over VOTE_FRAMES frames and emits a one-hot result with a valid strobe.
- Sits between the camera/VGA pixel path and the Arduino-facing RESULT bus. The RESULT bit layout is kept.

Parameters:
- CNT_W, 16, width of the per-frame pixel counters (saturating).
- R_MIN, 1, minimum PIXEL_IN[7:5] value for a red pixel.
- B_MIN, 1, minimum PIXEL_IN[1:0] value for a blue pixel.
- CNT_MIN, 5000, minimum winning pixel count for a frame to be non-null.
- VOTE_FRAMES, 10, frames per vote window; legal range 1..255.
- X_MIN, 0; X_MAX, 175; Y_MIN, 0; Y_MAX, 143: inclusive ROI bounds in VGA pixel coordinates.

Ports:
- CLK  in  1  pixel clock.
- RESET  in  1  asynchronous, active-high reset.
- PIXEL_IN  in  8  RGB332 pixel (R[7:5], G[4:2], B[1:0]).
- PIXEL_VALID  in  1  PIXEL_IN is a real pixel this cycle.
- VGA_PIXEL_X  in  10  current pixel column.
- VGA_PIXEL_Y  in  10  current pixel row.
- VGA_VSYNC_NEG  in  1  active-low vsync; its falling edge marks the frame boundary.
- RESULT  out  6  [3]=red, [4]=blue, [5]=null, [2:0]=0.
- RESULT_VALID  out  1  one-cycle pulse when RESULT is updated.
- FRAME_CLASS  out  2  last single-frame decision: 0=null, 1=red, 2=blue.

Behaviour:
- Reset (async assert, sync release):
  - RESULT=6'b100000 (null), RESULT_VALID=0, FRAME_CLASS=0.
  - All counters and votes cleared; vsync history register set to 1.
- Pixel classification (combinational):
  - 8'hFF is background.
  - Otherwise, red if R>=R_MIN.
  - Otherwise, blue if B>=B_MIN.
  - Otherwise background. Red has priority over blue.
- Counting:
  - A pixel is counted only if PIXEL_VALID=1 and X_MIN<=X<=X_MAX and Y_MIN<=Y<=Y_MAX.
  - cnt_red and cnt_blue increment by 1 per qualifying pixel and saturate at 2^CNT_W-1. They never wrap.
- Frame boundary: a cycle where vsync_q=1 and VGA_VSYNC_NEG=0. vsync_q is the registered VGA_VSYNC_NEG.
  - Frame decision, from the counts including all pixels before this cycle:
    - red if cnt_red>cnt_blue and cnt_red>=CNT_MIN;
    - blue if cnt_blue>cnt_red and cnt_blue>=CNT_MIN;
    - otherwise null (this includes ties).
  - FRAME_CLASS is registered with the decision at the boundary cycle. It is visible the next cycle.
  - Counters reload in the boundary cycle. A qualifying pixel in that same cycle is counted into the new frame, so the counter loads 1, not 0.
  - The matching vote counter (vote_red, vote_blue or vote_null; width = clog2(VOTE_FRAMES+1)) increments. frame_idx increments.
- Vote window close: this happens when the boundary brings frame_idx to VOTE_FRAMES. The current frame's vote is included, so no frame is dropped.
  - Result:
    - red if vr>vb and vr>=vn;
    - blue if vb>vr and vb>vn;
    - otherwise null.
  - RESULT is registered one-hot with bits [2:0]=0. RESULT_VALID=1 for exactly one cycle after the boundary.
  - Votes and frame_idx are cleared. The next window starts with the following frame.
- Latency: RESULT and RESULT_VALID change 1 cycle after the closing vsync falling edge.
- RESULT holds its value between windows, and also holds if vsync stops.
- With VOTE_FRAMES=1, every frame produces a result.
- Reset mid-frame or mid-window discards partial counts and votes. The first result after reset comes after VOTE_FRAMES complete boundaries.
  - The first boundary after reset closes a partial frame. It counts as a normal frame.
- Vsync held low produces no further boundaries. A glitch of one cycle high then low counts as a boundary; no filtering is applied.
- Parameter checks (elaboration-time error):
  - VOTE_FRAMES is 0 or greater than 255;
  - X_MIN>X_MAX or Y_MIN>Y_MAX;
  - CNT_MIN>=2^CNT_W.

Decomposition:
- Shared package color_pkg:
  - frame class encoding (CLS_NULL=0, CLS_RED=1, CLS_BLUE=2);
  - RESULT bit indices (RES_RED=3, RES_BLUE=4, RES_NULL=5);
  - SCREEN_WIDTH=176, SCREEN_HEIGHT=144;
  - the WHITE=8'hFF constant.
- Sub-module pixel_color_classify: combinational. Takes PIXEL_IN, R_MIN and B_MIN; outputs is_red and is_blue.
- The top module holds the ROI gate, counters, frame decision and vote FSM. The FSM states are IDLE_AFTER_RESET, COUNTING and VOTE_CLOSE; VOTE_CLOSE lasts a single cycle.

Test Plan (bench uses VOTE_FRAMES=3, CNT_MIN=100, CNT_W=16, full ROI):
- Reset, then idle -> RESULT=6'b100000, RESULT_VALID=0, FRAME_CLASS=0.
- 3 frames of 200 pixels 8'hE0 each -> FRAME_CLASS=1 after each frame. After the 3rd falling edge, RESULT=6'b001000 with RESULT_VALID high for exactly 1 cycle.
- Frames red, blue, blue, each 200 pixels (blue=8'h03) -> RESULT=6'b010000.
- Frames with 150 red and 150 blue (tie), then 99 red only, then 8'hFF only -> each FRAME_CLASS=0. RESULT=6'b100000.
- ROI X_MIN=50, X_MAX=59, with 300 red pixels spread over X=0..175 -> only in-window pixels are counted (checked against the model). CNT_W=8 with 300 red pixels -> the counter saturates at 255 and does not wrap; FRAME_CLASS=1.
- RESET asserted in frame 2 of a window -> votes cleared. The next RESULT_VALID comes only after 3 further boundaries. A red pixel on the boundary cycle is counted into the new frame.
